// File: rtl/qspi_slave_link.sv
// Mode-0 dual/quad SPI slave front end: synchronises the pins into CLK, deserialises
// received symbols into bytes (rxready) and serialises txdata back out (txready).
`timescale 1ns/1ps

module qspi_slave_link #(
    parameter int DWIDTH      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              QCK,
    input  logic              QSS,
    input  logic [DWIDTH-1:0] QD_IN,
    output logic [DWIDTH-1:0] QD_OUT,
    output logic [7:0]        rxdata,
    output logic              rxready,
    input  logic [7:0]        txdata,
    output logic              txready,
    output logic              active
);

    localparam int         N    = 8 / DWIDTH;
    localparam logic [2:0] LAST = 3'(N - 1);

    logic [SYNC_STAGES-1:0]             r_qck_sync;
    logic [SYNC_STAGES-1:0]             r_qss_sync;
    logic [SYNC_STAGES-1:0][DWIDTH-1:0] r_qd_sync;
    logic [SYNC_STAGES-1:0]             r_fresh;
    logic                               r_qck_prev;
    logic                               r_qss_prev;
    logic                               r_armed;
    logic [2:0]                         r_cnt;
    logic [7:0]                         r_rx_shift;
    logic [7:0]                         r_tx_shift;
    logic [7:0]                         r_rxdata;
    logic                               r_rxready;
    logic                               r_txready;

    logic              w_qck;
    logic              w_qss;
    logic [DWIDTH-1:0] w_qd;
    logic              w_rise;
    logic              w_fall;
    logic              w_sel;
    logic              w_sel_edge;
    logic [7:0]        w_rx_next;

    assign w_qck      = r_qck_sync[SYNC_STAGES-1];
    assign w_qss      = r_qss_sync[SYNC_STAGES-1];
    assign w_qd       = r_qd_sync[SYNC_STAGES-1];
    assign w_rise     = w_qck & ~r_qck_prev;
    assign w_fall     = ~w_qck & r_qck_prev;
    // After reset the chain is pre-filled with "deselected"; only a genuinely sampled
    // high QSS arms the link, so a master still holding QSS low must reselect.
    assign w_sel      = r_armed & ~w_qss;
    assign w_sel_edge = w_sel & r_qss_prev;
    assign w_rx_next  = (r_rx_shift << DWIDTH) | 8'(w_qd);

    assign QD_OUT  = w_sel ? r_tx_shift[7 -: DWIDTH] : '0;
    assign rxdata  = r_rxdata;
    assign rxready = r_rxready;
    assign txready = r_txready;
    assign active  = w_sel;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_qck_sync <= '0;
            r_qss_sync <= '1;
            r_qd_sync  <= '0;
            r_fresh    <= '0;
            r_qck_prev <= 1'b0;
            r_qss_prev <= 1'b1;
            r_armed    <= 1'b0;
            r_cnt      <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
            r_rxdata   <= 8'h00;
            r_rxready  <= 1'b0;
            r_txready  <= 1'b0;
        end else begin
            r_qck_sync <= {r_qck_sync[SYNC_STAGES-2:0], QCK};
            r_qss_sync <= {r_qss_sync[SYNC_STAGES-2:0], QSS};
            r_qd_sync  <= {r_qd_sync[SYNC_STAGES-2:0], QD_IN};
            r_fresh    <= {r_fresh[SYNC_STAGES-2:0], 1'b1};
            r_qck_prev <= w_qck;
            r_qss_prev <= w_qss;
            r_rxready  <= 1'b0;
            r_txready  <= 1'b0;
            if (r_fresh[SYNC_STAGES-1] && w_qss) begin
                r_armed <= 1'b1;
            end

            if (!w_sel) begin
                r_cnt      <= 3'd0;
                r_rx_shift <= 8'h00;
                r_tx_shift <= 8'h00;
            end else if (w_sel_edge) begin
                r_tx_shift <= txdata;
                r_txready  <= 1'b1;
            end else if (w_rise) begin
                r_rx_shift <= w_rx_next;
                if (r_cnt == LAST) begin
                    r_rxdata  <= w_rx_next;
                    r_rxready <= 1'b1;
                    r_cnt     <= 3'd0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end else if (w_fall) begin
                // cnt wraps to 0 on the last rise, so the first fall after it is the byte boundary
                if (r_cnt == 3'd0) begin
                    r_tx_shift <= txdata;
                    r_txready  <= 1'b1;
                end else begin
                    r_tx_shift <= r_tx_shift << DWIDTH;
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_slave_link.sv
// Directed bench for qspi_slave_link: three instances (DWIDTH 1, 2, 4) driven by
// a table of single-byte transactions plus hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_qspi_slave_link;

    typedef struct {
        int         inst;
        logic [7:0] mosi;
        logic [7:0] txb;
        logic [7:0] exp_rx;
        logic [3:0] exp_first;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic       qck [3];
    logic       qss [3];
    logic [7:0] txd [3];
    logic [0:0] qdi_1;
    logic [1:0] qdi_2;
    logic [3:0] qdi_4;
    logic [0:0] qdo_1;
    logic [1:0] qdo_2;
    logic [3:0] qdo_4;
    logic [3:0] qdo [3];
    logic [7:0] rxd [3];
    logic       rxr [3];
    logic       txr [3];
    logic       act [3];

    assign qdo[0] = {3'b000, qdo_1};
    assign qdo[1] = {2'b00, qdo_2};
    assign qdo[2] = qdo_4;

    qspi_slave_link #(.DWIDTH(1), .SYNC_STAGES(2)) u1 (
        .CLK(CLK), .RST(RST), .QCK(qck[0]), .QSS(qss[0]), .QD_IN(qdi_1), .QD_OUT(qdo_1),
        .rxdata(rxd[0]), .rxready(rxr[0]), .txdata(txd[0]), .txready(txr[0]), .active(act[0])
    );
    qspi_slave_link #(.DWIDTH(2), .SYNC_STAGES(2)) u2 (
        .CLK(CLK), .RST(RST), .QCK(qck[1]), .QSS(qss[1]), .QD_IN(qdi_2), .QD_OUT(qdo_2),
        .rxdata(rxd[1]), .rxready(rxr[1]), .txdata(txd[1]), .txready(txr[1]), .active(act[1])
    );
    qspi_slave_link #(.DWIDTH(4), .SYNC_STAGES(2)) u4 (
        .CLK(CLK), .RST(RST), .QCK(qck[2]), .QSS(qss[2]), .QD_IN(qdi_4), .QD_OUT(qdo_4),
        .rxdata(rxd[2]), .rxready(rxr[2]), .txdata(txd[2]), .txready(txr[2]), .active(act[2])
    );

    int         checks = 0;
    int         errors = 0;
    int         half   = 4;
    int         rxcnt [3];
    int         txcnt [3];
    logic [7:0] rxq [3][$];

    // Strobe monitor: every cycle a strobe is high counts, so a stretched pulse shows up.
    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (rxr[i] === 1'b1) begin
                rxcnt[i]++;
                rxq[i].push_back(rxd[i]);
            end
            if (txr[i] === 1'b1) txcnt[i]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    function automatic int dwof(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_qd(input int i, input logic [3:0] v);
        case (i)
            0:       qdi_1 = v[0:0];
            1:       qdi_2 = v[1:0];
            default: qdi_4 = v;
        endcase
    endtask

    task automatic sel(input int i);
        qss[i] = 1'b0;
        cyc(half);
    endtask

    task automatic desel(input int i);
        qss[i] = 1'b1;
        cyc(half);
    endtask

    task automatic rise(input int i, input logic [3:0] d);
        set_qd(i, d);
        qck[i] = 1'b1;
        cyc(half);
    endtask

    task automatic fall(input int i);
        qck[i] = 1'b0;
        cyc(half);
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        int dw;
        int v;
        dw = dwof(i);
        for (int s = 8 / dw - 1; s >= 0; s--) begin
            v = (int'(b) >> (s * dw)) & ((1 << dw) - 1);
            rise(i, 4'(v));
            fall(i);
        end
    endtask

    function automatic logic [7:0] last_rx(input int i);
        if (rxq[i].size() == 0) return 8'hxx;
        return rxq[i][rxq[i].size() - 1];
    endfunction

    vec_t       tbl [7];
    logic [3:0] exp_a [8];
    logic [7:0] sent [16];

    initial begin
        int         i;
        int         r0;
        int         t0;
        logic [7:0] echo;
        logic [7:0] b;

        tbl[0] = '{1, 8'hA5, 8'h5A, 8'hA5, 4'h1};
        tbl[1] = '{1, 8'h00, 8'hFF, 8'h00, 4'h3};
        tbl[2] = '{1, 8'hFF, 8'h80, 8'hFF, 4'h2};
        tbl[3] = '{2, 8'h3C, 8'hC3, 8'h3C, 4'hC};
        tbl[4] = '{2, 8'h96, 8'h1E, 8'h96, 4'h1};
        tbl[5] = '{0, 8'h81, 8'h7F, 8'h81, 4'h0};
        tbl[6] = '{0, 8'h4E, 8'hB0, 8'h4E, 4'h1};
        exp_a  = '{4'h1, 4'h2, 4'h2, 4'h3, 4'h0, 4'h0, 4'h3, 4'h3};

        RST   = 1'b1;
        qdi_1 = '0;
        qdi_2 = '0;
        qdi_4 = '0;
        for (int k = 0; k < 3; k++) begin
            qck[k]   = 1'b0;
            qss[k]   = 1'b1;
            txd[k]   = 8'h00;
            rxcnt[k] = 0;
            txcnt[k] = 0;
        end
        cyc(4);
        RST = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_rxdata%0d", k), 32'(rxd[k]), 32'h0);
            chk($sformatf("rst_rxready%0d", k), 32'(rxr[k]), 32'h0);
            chk($sformatf("rst_txready%0d", k), 32'(txr[k]), 32'h0);
            chk($sformatf("rst_qdout%0d", k), 32'(qdo[k]), 32'h0);
            chk($sformatf("rst_active%0d", k), 32'(act[k]), 32'h0);
        end
        cyc(6);

        // Table of single-byte transactions
        for (int k = 0; k < 7; k++) begin
            i      = tbl[k].inst;
            txd[i] = tbl[k].txb;
            r0     = rxcnt[i];
            t0     = txcnt[i];
            sel(i);
            chk($sformatf("v%0d_active", k), 32'(act[i]), 32'h1);
            chk($sformatf("v%0d_first_out", k), 32'(qdo[i]), 32'(tbl[k].exp_first));
            chk($sformatf("v%0d_sel_txready", k), 32'(txcnt[i] - t0), 32'd1);
            send_byte(i, tbl[k].mosi);
            chk($sformatf("v%0d_rxready_cnt", k), 32'(rxcnt[i] - r0), 32'd1);
            chk($sformatf("v%0d_rx_strobed", k), 32'(last_rx(i)), 32'(tbl[k].exp_rx));
            chk($sformatf("v%0d_rxdata", k), 32'(rxd[i]), 32'(tbl[k].exp_rx));
            chk($sformatf("v%0d_txready_cnt", k), 32'(txcnt[i] - t0), 32'd2);
            chk($sformatf("v%0d_reload_out", k), 32'(qdo[i]), 32'(tbl[k].exp_first));
            desel(i);
            chk($sformatf("v%0d_desel_out", k), 32'(qdo[i]), 32'h0);
            chk($sformatf("v%0d_desel_active", k), 32'(act[i]), 32'h0);
        end

        // DWIDTH=2 transmit: 0x5A at select, 0xC3 after the first txready
        txd[1] = 8'h5A;
        t0     = txcnt[1];
        r0     = rxcnt[1];
        sel(1);
        chk("tx_sel_out", 32'(qdo[1]), 32'h1);
        txd[1] = 8'hC3;
        for (int j = 0; j < 8; j++) begin
            rise(1, 4'h0);
            fall(1);
            chk($sformatf("tx_fall%0d_out", j + 1), 32'(qdo[1]), 32'(exp_a[j]));
            if (j == 3) chk("tx_txready_4th_fall", 32'(txcnt[1] - t0), 32'd2);
        end
        chk("tx_txready_total", 32'(txcnt[1] - t0), 32'd3);
        chk("tx_rxready_total", 32'(rxcnt[1] - r0), 32'd2);
        desel(1);

        // DWIDTH=4 two back-to-back bytes
        r0 = rxcnt[2];
        sel(2);
        send_byte(2, 8'h3C);
        send_byte(2, 8'hF0);
        chk("q4_rx_count", 32'(rxcnt[2] - r0), 32'd2);
        chk("q4_byte0", 32'(rxq[2][rxq[2].size() - 2]), 32'h3C);
        chk("q4_byte1", 32'(last_rx(2)), 32'hF0);
        desel(2);

        // DWIDTH=1 partial byte discarded, then a full byte
        r0 = rxcnt[0];
        sel(0);
        rise(0, 4'h1); fall(0);
        rise(0, 4'h0); fall(0);
        rise(0, 4'h1); fall(0);
        rise(0, 4'h1); fall(0);
        rise(0, 4'h0); fall(0);
        desel(0);
        chk("partial_no_strobe", 32'(rxcnt[0] - r0), 32'd0);
        chk("partial_rxdata_kept", 32'(rxd[0]), 32'h4E);
        sel(0);
        send_byte(0, 8'h81);
        chk("reselect_rx_count", 32'(rxcnt[0] - r0), 32'd1);
        chk("reselect_rxdata", 32'(rxd[0]), 32'h81);
        desel(0);

        // Reset mid-transfer (DWIDTH=2), link stays dead until a fresh select
        txd[1] = 8'hFF;
        sel(1);
        rise(1, 4'h3); fall(1);
        rise(1, 4'h3); fall(1);
        RST = 1'b1;
        cyc(1);
        chk("mrst_rxdata", 32'(rxd[1]), 32'h0);
        chk("mrst_rxready", 32'(rxr[1]), 32'h0);
        chk("mrst_txready", 32'(txr[1]), 32'h0);
        chk("mrst_qdout", 32'(qdo[1]), 32'h0);
        chk("mrst_active", 32'(act[1]), 32'h0);
        RST = 1'b0;
        r0  = rxcnt[1];
        t0  = txcnt[1];
        send_byte(1, 8'hA5);
        chk("mrst_ignored_rx", 32'(rxcnt[1] - r0), 32'd0);
        chk("mrst_ignored_tx", 32'(txcnt[1] - t0), 32'd0);
        chk("mrst_still_inactive", 32'(act[1]), 32'h0);
        chk("mrst_qdout_quiet", 32'(qdo[1]), 32'h0);
        desel(1);
        sel(1);
        chk("mrst_resel_txready", 32'(txcnt[1] - t0), 32'd1);
        send_byte(1, 8'hA5);
        chk("mrst_resel_rx_count", 32'(rxcnt[1] - r0), 32'd1);
        chk("mrst_resel_rxdata", 32'(rxd[1]), 32'hA5);
        desel(1);

        // Loopback at the SCLK limit: each phase SYNC_STAGES+1 clocks
        half = 3;
        rxq[1].delete();
        txd[1] = 8'h00;
        sel(1);
        for (int n = 0; n < 16; n++) begin
            b       = 8'($urandom);
            sent[n] = b;
            echo    = 8'h00;
            for (int s = 3; s >= 0; s--) begin
                echo = {echo[5:0], qdo[1][1:0]};
                rise(1, 4'((int'(b) >> (2 * s)) & 3));
                if (s == 0) txd[1] = rxd[1];
                fall(1);
            end
            chk($sformatf("loop_echo%0d", n), 32'(echo), (n == 0) ? 32'h0 : 32'(sent[n - 1]));
        end
        chk("loop_rx_count", 32'(rxq[1].size()), 32'd16);
        for (int n = 0; n < 16; n++) begin
            if (n < rxq[1].size()) chk($sformatf("loop_rx%0d", n), 32'(rxq[1][n]), 32'(sent[n]));
        end
        desel(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
